// File: rtl/dbg_pkg.sv
// Shared command and channel-state encodings for debug run control.
// The 2-bit codes match the TAP instruction decode and must not be renumbered.
package dbg_pkg;

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_HALT   = 2'b01,
        OP_STEP   = 2'b10,
        OP_RESUME = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HALT = 2'b01,
        ST_STEP = 2'b10
    } ch_state_e;

endpackage

// File: rtl/dbg_ch_fsm.sv
// Per-channel RUN/HALT/STEP state machine with breakpoint edge detect and cause flag.
// Latency: request at t is visible on clk_en/halted at t+1; no backpressure, requests are pre-qualified.
module dbg_ch_fsm
    import dbg_pkg::*;
(
    input  logic sys_clk,
    input  logic reset,
    input  logic halt_req,
    input  logic step_req,
    input  logic resume_req,
    input  logic step_expire,
    input  logic bp_en,
    input  logic bp_hit,
    output logic clk_en,
    output logic halted,
    output logic stepping,
    output logic bp_cause,
    output logic step_bp_exit
);

    ch_state_e state;
    ch_state_e state_nxt;
    logic      bp_cause_nxt;
    logic      bp_prev;
    logic      bp_lvl;
    logic      bp_evt;

    // Only a rising edge halts, so a level still high after RESUME is harmless.
    assign bp_lvl = bp_hit & bp_en;
    assign bp_evt = bp_lvl & ~bp_prev;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state    <= ST_RUN;
            bp_cause <= 1'b0;
            bp_prev  <= 1'b0;
            clk_en   <= 1'b1;
        end else begin
            state    <= state_nxt;
            bp_cause <= bp_cause_nxt;
            bp_prev  <= bp_lvl;
            clk_en   <= (state_nxt != ST_HALT);
        end
    end

    always_comb begin
        state_nxt    = state;
        bp_cause_nxt = bp_cause;
        unique case (state)
            ST_RUN: begin
                if (bp_evt) begin
                    state_nxt    = ST_HALT;
                    bp_cause_nxt = 1'b1;
                end else if (halt_req) begin
                    state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                if (step_req) begin
                    state_nxt    = ST_STEP;
                    bp_cause_nxt = 1'b0;
                end else if (resume_req) begin
                    state_nxt    = ST_RUN;
                    bp_cause_nxt = 1'b0;
                end
            end
            ST_STEP: begin
                if (bp_evt) begin
                    state_nxt    = ST_HALT;
                    bp_cause_nxt = 1'b1;
                end else if (halt_req || step_expire) begin
                    state_nxt = ST_HALT;
                end
            end
            default: state_nxt = ST_HALT;
        endcase
    end

    always_comb begin
        halted       = (state == ST_HALT);
        stepping     = (state == ST_STEP);
        step_bp_exit = (state == ST_STEP) && bp_evt;
    end

endmodule

// File: rtl/dbg_run_ctrl.sv
// Multi-channel debug run control: per-channel clock enables, shared step counter, breakpoint halts.
// Latency: command at t takes effect at t+1; STEP/RESUME while a step is running are dropped with cmd_err.
module dbg_run_ctrl
    import dbg_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    input  logic [N_CH-1:0]  cmd_mask,
    input  logic [CNT_W-1:0] step_cnt,
    input  logic [N_CH-1:0]  bp_en,
    input  logic [N_CH-1:0]  bp_hit,
    output logic [N_CH-1:0]  clk_en,
    output logic [N_CH-1:0]  halted,
    output logic [N_CH-1:0]  bp_cause,
    output logic             step_done,
    output logic             cmd_ready,
    output logic             cmd_err
);

    cmd_op_e          op;
    logic [N_CH-1:0]  halt_sel;
    logic [N_CH-1:0]  step_sel;
    logic [N_CH-1:0]  resume_sel;
    logic [N_CH-1:0]  stepping;
    logic [N_CH-1:0]  step_bp_exit;
    logic [N_CH-1:0]  survivors;
    logic [CNT_W-1:0] cnt_q;
    logic             any_step;
    logic             is_step;
    logic             is_resume;
    logic             step_acc;
    logic             resume_acc;
    logic             expire;
    logic             step_end;
    logic             bp_seen;
    logic             err_nxt;
    logic             done_nxt;

    assign op        = cmd_op_e'(cmd_op);
    assign any_step  = |stepping;
    assign cmd_ready = ~any_step;

    assign is_step    = cmd_valid && (op == OP_STEP);
    assign is_resume  = cmd_valid && (op == OP_RESUME);
    assign step_acc   = is_step   && cmd_ready && |(cmd_mask & halted);
    assign resume_acc = is_resume && cmd_ready && |(cmd_mask & halted);
    assign err_nxt    = (is_step && !step_acc) || (is_resume && !resume_acc);

    assign halt_sel   = (cmd_valid && (op == OP_HALT)) ? cmd_mask : '0;
    assign step_sel   = step_acc   ? cmd_mask : '0;
    assign resume_sel = resume_acc ? cmd_mask : '0;

    // Channels still stepping after this cycle's breakpoint exits and HALT aborts.
    assign survivors = stepping & ~step_bp_exit & ~halt_sel;
    assign expire    = any_step && (cnt_q == CNT_W'(1));
    assign step_end  = any_step && (expire || (survivors == '0));
    // A step ended purely by HALT aborts reports no completion.
    assign done_nxt  = step_end && ((|survivors) || bp_seen || (|step_bp_exit));

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            cnt_q     <= '0;
            bp_seen   <= 1'b0;
            step_done <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            if (step_acc) begin
                cnt_q <= (step_cnt == '0) ? CNT_W'(1) : step_cnt;
            end else if (step_end) begin
                cnt_q <= '0;
            end else if (any_step) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            bp_seen   <= step_end ? 1'b0 : (bp_seen | (|step_bp_exit));
            step_done <= done_nxt;
            cmd_err   <= err_nxt;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        dbg_ch_fsm u_fsm (
            .sys_clk      (sys_clk),
            .reset        (reset),
            .halt_req     (halt_sel[i]),
            .step_req     (step_sel[i]),
            .resume_req   (resume_sel[i]),
            .step_expire  (expire),
            .bp_en        (bp_en[i]),
            .bp_hit       (bp_hit[i]),
            .clk_en       (clk_en[i]),
            .halted       (halted[i]),
            .stepping     (stepping[i]),
            .bp_cause     (bp_cause[i]),
            .step_bp_exit (step_bp_exit[i])
        );
    end

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Scoreboard bench for dbg_run_ctrl: driver queues expected output snapshots per cycle,
// a negedge monitor pops and compares them.
module tb_dbg_run_ctrl;
    import dbg_pkg::*;

    logic       sys_clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [3:0] cmd_mask;
    logic [7:0] step_cnt;
    logic [3:0] bp_en;
    logic [3:0] bp_hit;
    logic [3:0] clk_en;
    logic [3:0] halted;
    logic [3:0] bp_cause;
    logic       step_done;
    logic       cmd_ready;
    logic       cmd_err;

    dbg_run_ctrl #(.N_CH(4), .CNT_W(8)) dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_mask  (cmd_mask),
        .step_cnt  (step_cnt),
        .bp_en     (bp_en),
        .bp_hit    (bp_hit),
        .clk_en    (clk_en),
        .halted    (halted),
        .bp_cause  (bp_cause),
        .step_done (step_done),
        .cmd_ready (cmd_ready),
        .cmd_err   (cmd_err)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        string       name;
        logic [14:0] val;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    logic [14:0] act;
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic expect_at(input int at, input string nm, input logic [3:0] ce,
                             input logic [3:0] h, input logic [3:0] bc,
                             input logic sd, input logic rdy, input logic err);
        exp_t e;
        e.at   = at;
        e.name = nm;
        e.val  = {ce, h, bc, sd, rdy, err};
        sb.push_back(e);
    endtask

    always @(negedge sys_clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            cur = sb.pop_front();
            act = {clk_en, halted, bp_cause, step_done, cmd_ready, cmd_err};
            n_vec++;
            if (cur.at != cyc) begin
                n_bad++;
                $display("FAIL %s: expectation for cycle %0d sampled late at cycle %0d", cur.name, cur.at, cyc);
            end else if (act !== cur.val) begin
                n_bad++;
                $display("FAIL %s @%0d: got ce=%b halted=%b cause=%b done=%b rdy=%b err=%b, expected ce=%b halted=%b cause=%b done=%b rdy=%b err=%b",
                         cur.name, cyc, act[14:11], act[10:7], act[6:3], act[2], act[1], act[0],
                         cur.val[14:11], cur.val[10:7], cur.val[6:3], cur.val[2], cur.val[1], cur.val[0]);
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    // Drives one command cycle; returns its cycle number with the bus idled again at t+1.
    task automatic issue(input logic [1:0] op, input logic [3:0] m, input logic [7:0] n,
                         input logic [3:0] bph, output int t);
        tick();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_mask  = m;
        step_cnt  = n;
        bp_hit    = bph;
        t         = cyc;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_mask  = 4'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int t2;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_mask  = 4'h0;
        step_cnt  = 8'd0;
        bp_en     = 4'h0;
        bp_hit    = 4'h0;
        tick();
        tick();
        reset = 1'b0;
        expect_at(cyc, "reset", 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);

        issue(OP_HALT, 4'b0101, 8'd0, 4'h0, t);
        expect_at(t+1, "halt_0101", 4'b1010, 4'b0101, 4'h0, 1'b0, 1'b1, 1'b0);
        issue(OP_HALT, 4'b1010, 8'd0, 4'h0, t);
        expect_at(t+1, "halt_all", 4'h0, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0);

        issue(OP_STEP, 4'b0011, 8'd3, 4'h0, t);
        expect_at(t+1, "step3_c1",    4'b0011, 4'b1100, 4'h0, 1'b0, 1'b0, 1'b0);
        expect_at(t+2, "step3_c2",    4'b0011, 4'b1100, 4'h0, 1'b0, 1'b0, 1'b0);
        expect_at(t+3, "step3_c3",    4'b0011, 4'b1100, 4'h0, 1'b0, 1'b0, 1'b0);
        expect_at(t+4, "step3_done",  4'h0,    4'hF,    4'h0, 1'b1, 1'b1, 1'b0);
        expect_at(t+5, "step3_after", 4'h0,    4'hF,    4'h0, 1'b0, 1'b1, 1'b0);
        wait_until(t+4);

        issue(OP_STEP, 4'b0001, 8'd0, 4'h0, t);
        expect_at(t+1, "step0_c1",   4'b0001, 4'b1110, 4'h0, 1'b0, 1'b0, 1'b0);
        expect_at(t+2, "step0_done", 4'h0,    4'hF,    4'h0, 1'b1, 1'b1, 1'b0);

        issue(OP_STEP, 4'b0100, 8'd4, 4'h0, t);
        expect_at(t+1, "step4_c1", 4'b0100, 4'b1011, 4'h0, 1'b0, 1'b0, 1'b0);
        issue(OP_RESUME, 4'b0100, 8'd0, 4'h0, t2);
        expect_at(t2+1, "resume_busy", 4'b0100, 4'b1011, 4'h0, 1'b0, 1'b0, 1'b1);
        expect_at(t+5,  "step4_done",  4'h0,    4'hF,    4'h0, 1'b1, 1'b1, 1'b0);
        wait_until(t+5);

        issue(OP_RESUME, 4'hF, 8'd0, 4'h0, t);
        expect_at(t+1, "resume_all", 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        tick();
        bp_en  = 4'b0100;
        bp_hit = 4'b0100;
        t = cyc;
        expect_at(t+1, "bp_halt", 4'b1011, 4'b0100, 4'b0100, 1'b0, 1'b1, 1'b0);
        expect_at(t+2, "bp_hold", 4'b1011, 4'b0100, 4'b0100, 1'b0, 1'b1, 1'b0);
        wait_until(t+2);
        issue(OP_RESUME, 4'b0100, 8'd0, 4'b0100, t);
        expect_at(t+1, "bp_resume",     4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        expect_at(t+3, "bp_level_held", 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        wait_until(t+3);
        bp_hit = 4'h0;
        bp_en  = 4'h0;

        issue(OP_HALT, 4'hF, 8'd0, 4'h0, t);
        expect_at(t+1, "halt_all2", 4'h0, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0);
        issue(OP_STEP, 4'b0001, 8'd10, 4'h0, t);
        expect_at(t+1, "step10_c1", 4'b0001, 4'b1110, 4'h0, 1'b0, 1'b0, 1'b0);
        issue(OP_HALT, 4'b0001, 8'd0, 4'h0, t2);
        expect_at(t2+1, "abort",        4'h0, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0);
        expect_at(t2+2, "abort_nodone", 4'h0, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0);
        wait_until(t2+2);

        issue(OP_STEP, 4'hF, 8'd10, 4'h0, t);
        expect_at(t+1, "stepall_c1", 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_at(cyc,   "reset_mid",    4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        expect_at(cyc+1, "reset_nodone", 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);

        issue(OP_RESUME, 4'b0001, 8'd0, 4'h0, t);
        expect_at(t+1, "resume_running", 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
        expect_at(t+2, "err_clear",      4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);

        bp_en = 4'b0010;
        issue(OP_HALT, 4'b0010, 8'd0, 4'b0010, t);
        expect_at(t+1, "halt_and_bp", 4'b1101, 4'b0010, 4'b0010, 1'b0, 1'b1, 1'b0);

        issue(OP_STEP, 4'b0001, 8'd2, 4'b0010, t);
        expect_at(t+1, "step_running", 4'b1101, 4'b0010, 4'b0010, 1'b0, 1'b1, 1'b1);

        issue(OP_STEP, 4'b0010, 8'd5, 4'b0010, t);
        expect_at(t+1, "stepbp_c1", 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        bp_hit = 4'h0;
        tick();
        bp_hit = 4'b0010;
        expect_at(t+3, "stepbp_halt",  4'b1101, 4'b0010, 4'b0010, 1'b1, 1'b1, 1'b0);
        expect_at(t+4, "stepbp_after", 4'b1101, 4'b0010, 4'b0010, 1'b0, 1'b1, 1'b0);
        wait_until(t+5);

        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations never sampled, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
